// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
// Holds the fetch FSM encoding, the HALT opcode and the instruction geometry.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD0     = 4'd1,
    S_RD1     = 4'd2,
    S_RD2     = 4'd3,
    S_RD3     = 4'd4,
    S_CAP     = 4'd5,
    S_ISSUE   = 4'd6,
    S_WAIT_BR = 4'd7,
    S_HALTED  = 4'd8
  } state_t;

  localparam logic [10:0] HALT_OPCODE     = 11'h7FF;
  localparam int          INSTR_BYTES     = 4;
  localparam int          DEFAULT_IMEM_AW = 12;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:21] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instr_byte_assembler.sv
// Little-endian 4-byte capture register: byte_idx 0 lands in [7:0], 3 in [31:24].
// One-cycle write, no backpressure; clear has priority over capture.
module instr_byte_assembler
  import cpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       capture,
  input  logic [1:0]                 byte_idx,
  input  logic [7:0]                 byte_data,
  output logic [8*INSTR_BYTES-1:0]   word
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (capture) begin
      word[{byte_idx, 3'b000} +: 8] <= byte_data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Serial byte fetch of 32-bit instructions, issue to decode, then branch redirect.
// 6 cycles per instruction; holds instr/instr_pc while decode stalls instr_ready.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = 64,
  parameter int unsigned         IMEM_AW   = DEFAULT_IMEM_AW,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned         MAX_INSTR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_rd,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [7:0]          imem_rdata,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                br_valid,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic                halted,
  output logic                fault,
  output logic [31:0]         instr_count
);

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH:0]   pc_plus4;
  logic                pc_wrap;
  logic                addr_bad;
  logic                handshake;
  logic [31:0]         count_inc;
  logic                cap_hit;
  logic                stop_fetch;
  logic                redirect;
  logic                asm_clear;
  logic                asm_capture;
  logic [1:0]          asm_idx;

  // The carry bit of pc_plus4 flags a sequential wrap past the top of the PC space.
  assign pc_plus4  = {1'b0, pc} + (PC_WIDTH+1)'(INSTR_BYTES);
  assign pc_nxt    = br_taken ? br_target : pc_plus4[PC_WIDTH-1:0];
  assign pc_wrap   = !br_taken && pc_plus4[PC_WIDTH];
  assign addr_bad  = pc_wrap || (pc_nxt[1:0] != 2'b00) || ((pc_nxt >> IMEM_AW) != '0);

  assign handshake  = (state == S_ISSUE) && instr_ready;
  assign count_inc  = (&instr_count) ? instr_count : instr_count + 32'd1;
  assign cap_hit    = (MAX_INSTR != 0) && (count_inc == 32'(MAX_INSTR));
  assign stop_fetch = is_halt(instr) || cap_hit;
  assign redirect   = br_valid && ((handshake && !stop_fetch) || (state == S_WAIT_BR));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RD0;
      S_RD0:     state_nxt = S_RD1;
      S_RD1:     state_nxt = S_RD2;
      S_RD2:     state_nxt = S_RD3;
      S_RD3:     state_nxt = S_CAP;
      S_CAP:     state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (instr_ready) begin
          if (stop_fetch)    state_nxt = S_HALTED;
          else if (br_valid) state_nxt = addr_bad ? S_HALTED : S_RD0;
          else               state_nxt = S_WAIT_BR;
        end
      end
      S_WAIT_BR: if (br_valid) state_nxt = addr_bad ? S_HALTED : S_RD0;
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Byte k is on imem_rdata one cycle after RDk, hence the one-state capture lag.
  always_comb begin
    imem_rd     = 1'b0;
    imem_addr   = '0;
    asm_clear   = 1'b0;
    asm_capture = 1'b0;
    asm_idx     = 2'd0;
    case (state)
      S_RD0: begin
        imem_rd   = 1'b1;
        imem_addr = pc[IMEM_AW-1:0];
        asm_clear = 1'b1;
      end
      S_RD1: begin
        imem_rd     = 1'b1;
        imem_addr   = pc[IMEM_AW-1:0] + IMEM_AW'(1);
        asm_capture = 1'b1;
        asm_idx     = 2'd0;
      end
      S_RD2: begin
        imem_rd     = 1'b1;
        imem_addr   = pc[IMEM_AW-1:0] + IMEM_AW'(2);
        asm_capture = 1'b1;
        asm_idx     = 2'd1;
      end
      S_RD3: begin
        imem_rd     = 1'b1;
        imem_addr   = pc[IMEM_AW-1:0] + IMEM_AW'(3);
        asm_capture = 1'b1;
        asm_idx     = 2'd2;
      end
      S_CAP: begin
        asm_capture = 1'b1;
        asm_idx     = 2'd3;
      end
      default: ;
    endcase
  end

  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALTED);
  assign instr_pc    = pc;

  // A rejected redirect leaves pc at the instruction that produced it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      if (handshake) begin
        instr_count <= count_inc;
      end
      if (redirect) begin
        if (addr_bad) begin
          fault <= 1'b1;
        end else begin
          pc <= pc_nxt;
        end
      end
    end
  end

  instr_byte_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .capture   (asm_capture),
    .byte_idx  (asm_idx),
    .byte_data (imem_rdata),
    .word      (instr)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: one fetch_sequencer for the main flow, a second with MAX_INSTR=30.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, instr_ready, br_valid, br_taken;
  logic [63:0] br_target;
  logic        imem_rd;
  logic [11:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid, halted, fault;
  logic [31:0] instr_count;

  logic        c_start;
  logic        c_imem_rd;
  logic [11:0] c_imem_addr;
  logic [7:0]  c_imem_rdata;
  logic [31:0] c_instr;
  logic [63:0] c_instr_pc;
  logic        c_instr_valid, c_halted, c_fault;
  logic [31:0] c_instr_count;
  logic        c_one = 1'b1;
  logic [63:0] c_zero_target = 64'h0;

  logic [7:0]  mem [0:4095];
  logic [11:0] addr_q[$];

  int tests = 0;
  int fails = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  fetch_sequencer #(.MAX_INSTR(30)) dut_cap (
    .clk(clk), .rst_n(rst_n), .start(c_start),
    .imem_rd(c_imem_rd), .imem_addr(c_imem_addr), .imem_rdata(c_imem_rdata),
    .instr(c_instr), .instr_pc(c_instr_pc), .instr_valid(c_instr_valid), .instr_ready(c_one),
    .br_valid(c_one), .br_taken(c_one), .br_target(c_zero_target),
    .halted(c_halted), .fault(c_fault), .instr_count(c_instr_count)
  );

  always @(posedge clk) begin
    if (imem_rd)   imem_rdata   <= mem[imem_addr];
    if (c_imem_rd) c_imem_rdata <= mem[c_imem_addr];
  end

  always @(negedge clk) begin
    if (imem_rd === 1'b1) addr_q.push_back(imem_addr);
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (instr_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake_with(input logic bv, input logic bt, input logic [63:0] tgt);
    instr_ready = 1'b1; br_valid = bv; br_taken = bt; br_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({instr_valid, imem_rd, halted, fault} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000", {instr_valid, imem_rd, halted, fault}); fails++;
    end
    tests++;
    if (instr !== 32'h0 || imem_addr !== 12'h0) begin
      $display("FAIL reset_data: instr=%h addr=%h want 0", instr, imem_addr); fails++;
    end
    tests++;
    if (instr_pc !== 64'h0 || instr_count !== 32'h0) begin
      $display("FAIL reset_pc_count: pc=%h count=%0d want 0", instr_pc, instr_count); fails++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_straight_line();
    int n;
    do_start();
    wait_valid(n);
    tests++;
    if (n !== 6) begin $display("FAIL first_latency: got %0d want 6", n); fails++; end
    tests++;
    if (instr !== 32'h8B00028B || instr_pc !== 64'h0) begin
      $display("FAIL instr0: got %h@%h want 8b00028b@0", instr, instr_pc); fails++;
    end
    handshake_with(1'b1, 1'b0, 64'h0);
    tests++;
    if (instr_count !== 32'd1) begin $display("FAIL count_after_1: got %0d want 1", instr_count); fails++; end
    wait_valid(n);
    tests++;
    if (n !== 6) begin $display("FAIL steady_period: got %0d want 6", n); fails++; end
    tests++;
    if (instr !== 32'hD2800020 || instr_pc !== 64'h4) begin
      $display("FAIL instr1: got %h@%h want d2800020@4", instr, instr_pc); fails++;
    end
    handshake_with(1'b1, 1'b0, 64'h0);
    tests++;
    if (instr_count !== 32'd2) begin $display("FAIL count_after_2: got %0d want 2", instr_count); fails++; end
  endtask

  task automatic test_backpressure();
    int n;
    logic ok;
    wait_valid(n);
    tests++;
    if (instr !== 32'h91000421 || instr_pc !== 64'h8) begin
      $display("FAIL instr2: got %h@%h want 91000421@8", instr, instr_pc); fails++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ok = (instr === 32'h91000421) && (instr_pc === 64'h8) && (imem_rd === 1'b0)
           && (instr_valid === 1'b1) && (instr_count === 32'd2);
      tests++;
      if (!ok) begin
        $display("FAIL stall_hold cyc %0d: instr=%h pc=%h rd=%b vld=%b cnt=%0d want 91000421/8/0/1/2",
                 i, instr, instr_pc, imem_rd, instr_valid, instr_count); fails++;
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    tests++;
    if (instr_count !== 32'd3) begin $display("FAIL count_on_release: got %0d want 3", instr_count); fails++; end
    @(negedge clk);
    tests++;
    if (instr_count !== 32'd3 || instr_valid !== 1'b0) begin
      $display("FAIL count_once: cnt=%0d vld=%b want 3/0", instr_count, instr_valid); fails++;
    end
  endtask

  task automatic test_taken_branch();
    int n;
    logic ok;
    addr_q.delete();
    @(negedge clk);
    tests++;
    if (instr_valid !== 1'b0 || imem_rd !== 1'b0 || addr_q.size() != 0) begin
      $display("FAIL wait_br_idle: vld=%b rd=%b reads=%0d want 0/0/0", instr_valid, imem_rd, addr_q.size()); fails++;
    end
    br_valid = 1'b1; br_taken = 1'b1; br_target = 64'h40;
    @(negedge clk);
    br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
    wait_valid(n);
    ok = (addr_q.size() == 4);
    if (ok) for (int i = 0; i < 4; i++) if (addr_q[i] !== 12'h40 + 12'(i)) ok = 1'b0;
    tests++;
    if (!ok) begin
      $display("FAIL branch_addrs: got %0d reads first=%h want 40,41,42,43", addr_q.size(),
               (addr_q.size() > 0) ? addr_q[0] : 12'hFFF); fails++;
    end
    tests++;
    if (instr !== 32'h11CCBBAA || instr_pc !== 64'h40) begin
      $display("FAIL branch_instr: got %h@%h want 11ccbbaa@40", instr, instr_pc); fails++;
    end
    handshake_with(1'b1, 1'b1, 64'hC);
  endtask

  task automatic test_halt();
    int n;
    wait_valid(n);
    tests++;
    if (instr !== 32'hFFE00000 || instr_pc !== 64'hC) begin
      $display("FAIL halt_instr: got %h@%h want ffe00000@c", instr, instr_pc); fails++;
    end
    addr_q.delete();
    handshake_with(1'b1, 1'b1, 64'h0);
    tests++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || fault !== 1'b0 || instr_pc !== 64'hC || instr_count !== 32'd5) begin
      $display("FAIL halt_state: h=%b v=%b f=%b pc=%h cnt=%0d want 1/0/0/c/5",
               halted, instr_valid, fault, instr_pc, instr_count); fails++;
    end
    do_start();
    repeat (8) @(negedge clk);
    tests++;
    if (addr_q.size() != 0 || halted !== 1'b1 || instr_count !== 32'd5) begin
      $display("FAIL halt_sticky: reads=%0d h=%b cnt=%0d want 0/1/5", addr_q.size(), halted, instr_count); fails++;
    end
  endtask

  task automatic test_fault();
    int n;
    logic [63:0] tgt;
    for (int k = 0; k < 2; k++) begin
      tgt = (k == 0) ? 64'h102 : 64'h1000;
      pulse_reset();
      do_start();
      wait_valid(n);
      addr_q.delete();
      handshake_with(1'b1, 1'b1, tgt);
      tests++;
      if ({halted, fault} !== 2'b11 || instr_pc !== 64'h0 || instr_count !== 32'd1) begin
        $display("FAIL fault_state tgt=%h: h=%b f=%b pc=%h cnt=%0d want 1/1/0/1",
                 tgt, halted, fault, instr_pc, instr_count); fails++;
      end
      repeat (6) @(negedge clk);
      tests++;
      if (addr_q.size() != 0 || instr_valid !== 1'b0) begin
        $display("FAIL fault_no_read tgt=%h: reads=%0d vld=%b want 0/0", tgt, addr_q.size(), instr_valid); fails++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_reset();
    do_start();
    repeat (2) @(negedge clk);
    tests++;
    if (imem_rd !== 1'b1 || imem_addr !== 12'h2) begin
      $display("FAIL rd2_addr: rd=%b addr=%h want 1/002", imem_rd, imem_addr); fails++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({instr_valid, imem_rd, halted, fault} !== 4'b0000 || imem_addr !== 12'h0 || instr !== 32'h0
        || instr_pc !== 64'h0 || instr_count !== 32'h0) begin
      $display("FAIL mid_reset_clear: flags=%b addr=%h instr=%h pc=%h cnt=%0d want all 0",
               {instr_valid, imem_rd, halted, fault}, imem_addr, instr, instr_pc, instr_count); fails++;
    end
    rst_n = 1'b1;
    do_start();
    wait_valid(n);
    tests++;
    if (n !== 6 || instr !== 32'h8B00028B || instr_pc !== 64'h0) begin
      $display("FAIL refetch: lat=%0d instr=%h pc=%h want 6/8b00028b/0", n, instr, instr_pc); fails++;
    end
  endtask

  task automatic test_cap();
    int n;
    @(negedge clk); c_start = 1'b1;
    @(negedge clk); c_start = 1'b0;
    n = 1;
    while (c_halted !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 181) begin $display("FAIL cap_cycles: got %0d want 181", n); fails++; end
    tests++;
    if (c_instr_count !== 32'd30 || c_fault !== 1'b0 || c_instr_pc !== 64'h0) begin
      $display("FAIL cap_state: cnt=%0d f=%b pc=%h want 30/0/0", c_instr_count, c_fault, c_instr_pc); fails++;
    end
    repeat (12) @(negedge clk);
    tests++;
    if (c_instr_count !== 32'd30 || c_halted !== 1'b1 || c_imem_rd !== 1'b0) begin
      $display("FAIL cap_sticky: cnt=%0d h=%b rd=%b want 30/1/0", c_instr_count, c_halted, c_imem_rd); fails++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[0],  mem[1],  mem[2],  mem[3]}  = {8'h8B, 8'h02, 8'h00, 8'h8B};
    {mem[4],  mem[5],  mem[6],  mem[7]}  = {8'h20, 8'h00, 8'h80, 8'hD2};
    {mem[8],  mem[9],  mem[10], mem[11]} = {8'h21, 8'h04, 8'h00, 8'h91};
    {mem[12], mem[13], mem[14], mem[15]} = {8'h00, 8'h00, 8'hE0, 8'hFF};
    {mem[64], mem[65], mem[66], mem[67]} = {8'hAA, 8'hBB, 8'hCC, 8'h11};
    start = 1'b0; c_start = 1'b0; instr_ready = 1'b0;
    br_valid = 1'b0; br_taken = 1'b0; br_target = '0;

    test_reset();
    test_straight_line();
    test_backpressure();
    test_taken_branch();
    test_halt();
    test_fault();
    test_reset_mid();
    test_cap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
